sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port between three requesters: N64 PI bus (port 0), CPU SoC bus (port 1), USB/FTDI DMA engine (port 2).
- Port 0 gets priority, bounded by a starvation limit. Ports 1 and 2 are served round-robin.
- Exactly one 16-bit transaction is outstanding downstream at a time. The block sits between the bus masters and the SDRAM controller inside the system clock domain.

Parameters:
- ADDR_WIDTH, 26, SDRAM byte-address width passed through unchanged.
- MAX_PI_BURST, 4, maximum consecutive port-0 grants while port 1 or 2 is pending; range 1..15.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  3  per-port request; bit n belongs to port n. The requester holds it until ack[n].
- write  in  3  per-port direction; 1 = write. Must be stable while req is held.
- address  in  3xADDR_WIDTH  per-port address, packed with port n in slice n.
- wdata  in  3x16  per-port write data.
- wmask  in  3x2  per-port byte enables; 1 = byte written.
- ack  out  3  one-cycle completion pulse for port n.
- rdata  out  16  read data. Valid in the cycle ack[n] is high for a read.
- mem_request  out  1  request to the SDRAM controller.
- mem_write  out  1  direction to the controller.
- mem_address  out  ADDR_WIDTH  address to the controller.
- mem_wdata  out  16  write data to the controller.
- mem_wmask  out  2  byte enables to the controller.
- mem_ack  in  1  one-cycle pulse from the controller; transaction done. mem_rdata is valid in the same cycle.
- mem_rdata  in  16  read data from the controller.
- grant_id  out  2  index of the port being served; 3 = none. For debug/PMOD.

Behaviour:
- Reset values: ack=0, rdata=0, mem_request=0, mem_write=0, mem_address=0, mem_wdata=0, mem_wmask=0, grant_id=3. Internally rr_last=2 and pi_count=0.
- Reset asserted mid-transaction aborts immediately with no ack. Requesters re-request after reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE, when any req bit is high:
  - Select a winner and latch its write/address/wdata/wmask into the mem_* registers.
  - Set mem_request=1 and grant_id to the winner, then go to BUSY.
  - mem_request therefore rises 1 cycle after req is first seen.
- Winner selection:
  - If req[0]=1 and (pi_count < MAX_PI_BURST, or req[2:1]=0), grant port 0.
  - Otherwise grant among ports 1 and 2 round-robin: the port not equal to rr_last wins if requesting, else the other one.
  - Granting port 1 or 2 updates rr_last to that port.
- pi_count:
  - Increments on a port-0 grant while req[2:1]!=0, saturating at 15.
  - Resets to 0 on any port-1 or port-2 grant.
  - Resets to 0 on a port-0 grant while req[2:1]=0.
- BUSY:
  - mem_request and the mem_* signals stay constant until mem_ack.
  - On mem_ack: clear mem_request, register mem_rdata into rdata (reads only; writes leave rdata unchanged), pulse ack[grant_id] in the next cycle, go to DONE.
- DONE: ack pulse is high for 1 cycle. Return to IDLE with grant_id=3.
- Minimum spacing is 3 cycles per transaction. A new grant is possible on the cycle after DONE.
- req[n] is sampled in IDLE only. A request raised during BUSY/DONE waits for the next IDLE.
- Dropping req before ack is a protocol violation. The arbiter completes the transaction regardless and still pulses ack.
- mem_ack outside BUSY is ignored.
- Simultaneous req on all ports:
  - With MAX_PI_BURST=4 and continuous demand, the grant order is 0,0,0,0,1,0,0,0,0,2,...
- Only one ack bit is ever high in a cycle.

Test Plan:
- Single read, port 1, addr 0x0001000, mem_ack 5 cycles after mem_request, mem_rdata=0xBEEF -> mem_request rises 1 cycle after req, mem_address=0x0001000, mem_write=0, ack=3'b010 one cycle after mem_ack, rdata=0xBEEF, grant_id returns to 3.
- Write, port 2, wdata=0x1234, wmask=2'b01 -> mem_write=1, mem_wdata=0x1234, mem_wmask=01, ack=3'b100, rdata unchanged.
- All three req held high for 12 transactions, mem_ack always 2 cycles after request -> grant_id sequence 0,0,0,0,1,0,0,0,0,2,0,0.
- Port 0 alone for 20 transactions -> every grant goes to 0 with no forced gaps. Then raise req[1] -> port 1 is granted within 5 grants.
- Ports 1 and 2 only, continuous -> grant_id alternates 1,2,1,2. After reset the first winner is 1.
- Reset asserted during BUSY, before mem_ack -> mem_request=0 and grant_id=3 immediately, no ack. A later stray mem_ack produces no ack.

Source files
------------

// File: rtl/sdram_arbiter.sv
// ----------------------------------------------------------------------------
// sdram_arbiter
// Shares one SDRAM controller port between three requesters:
//   port 0 = N64 PI bus (priority, bounded by a starvation limit)
//   port 1 = CPU SoC bus, port 2 = USB/FTDI DMA (round-robin between them)
// Exactly one 16-bit transaction is outstanding downstream at a time.
//
// Ports:
//   clk, reset              system clock, asynchronous active-high reset
//   req/write[2:0]          per-port request and direction (1 = write)
//   address/wdata/wmask     per-port payloads, port n in slice n
//   ack[2:0]                one-cycle completion pulse per port
//   rdata                   read data, valid while ack[n] is high for a read
//   mem_*                   request/payload to, ack/read data from controller
//   grant_id                port being served, 3 = none (debug/PMOD)
// ----------------------------------------------------------------------------
module sdram_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 26,
   parameter int unsigned MAX_PI_BURST = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [2:0]              req,
   input  logic [2:0]              write,
   input  logic [3*ADDR_WIDTH-1:0] address,
   input  logic [47:0]             wdata,
   input  logic [5:0]              wmask,
   output logic [2:0]              ack,
   output logic [15:0]             rdata,
   output logic                    mem_request,
   output logic                    mem_write,
   output logic [ADDR_WIDTH-1:0]   mem_address,
   output logic [15:0]             mem_wdata,
   output logic [1:0]              mem_wmask,
   input  logic                    mem_ack,
   input  logic [15:0]             mem_rdata,
   output logic [1:0]              grant_id
);

   localparam int unsigned CNT_WIDTH = 4;
   localparam logic [1:0]  NO_GRANT  = 2'd3;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                 state, state_d;
   logic [1:0]             rr_last, rr_last_d;
   logic [CNT_WIDTH-1:0]   pi_count, pi_count_d;

   logic [2:0]             ack_d;
   logic [15:0]            rdata_d;
   logic                   mem_request_d;
   logic                   mem_write_d;
   logic [ADDR_WIDTH-1:0]  mem_address_d;
   logic [15:0]            mem_wdata_d;
   logic [1:0]             mem_wmask_d;
   logic [1:0]             grant_id_d;

   logic                   other_req;
   logic [1:0]             winner;
   logic                   sel_write;
   logic [ADDR_WIDTH-1:0]  sel_address;
   logic [15:0]            sel_wdata;
   logic [1:0]             sel_wmask;

   assign other_req = |req[2:1];

   // Winner: port 0 unless it has used up its burst while others wait;
   // otherwise the port that was not served last among 1 and 2.
   always_comb begin
      winner = NO_GRANT;
      if (req[0] && ((pi_count < CNT_WIDTH'(MAX_PI_BURST)) || !other_req)) begin
         winner = 2'd0;
      end else if (req[1] && req[2]) begin
         winner = (rr_last == 2'd1) ? 2'd2 : 2'd1;
      end else if (req[1]) begin
         winner = 2'd1;
      end else if (req[2]) begin
         winner = 2'd2;
      end
   end

   // Payload mux for the winning port.
   always_comb begin
      sel_write   = write[2];
      sel_address = address[2*ADDR_WIDTH +: ADDR_WIDTH];
      sel_wdata   = wdata[32 +: 16];
      sel_wmask   = wmask[4 +: 2];
      case (winner)
         2'd0: begin
            sel_write   = write[0];
            sel_address = address[0 +: ADDR_WIDTH];
            sel_wdata   = wdata[0 +: 16];
            sel_wmask   = wmask[0 +: 2];
         end
         2'd1: begin
            sel_write   = write[1];
            sel_address = address[ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata   = wdata[16 +: 16];
            sel_wmask   = wmask[2 +: 2];
         end
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (|req)   state_d = BUSY;
         BUSY:    if (mem_ack) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs and arbitration state.
   always_comb begin
      ack_d         = 3'b000;
      rdata_d       = rdata;
      mem_request_d = mem_request;
      mem_write_d   = mem_write;
      mem_address_d = mem_address;
      mem_wdata_d   = mem_wdata;
      mem_wmask_d   = mem_wmask;
      grant_id_d    = grant_id;
      rr_last_d     = rr_last;
      pi_count_d    = pi_count;
      case (state)
         IDLE: begin
            if (|req) begin
               mem_request_d = 1'b1;
               mem_write_d   = sel_write;
               mem_address_d = sel_address;
               mem_wdata_d   = sel_wdata;
               mem_wmask_d   = sel_wmask;
               grant_id_d    = winner;
               if (winner == 2'd0) begin
                  // Burst count only grows while someone else is waiting.
                  if (!other_req) begin
                     pi_count_d = '0;
                  end else if (pi_count != '1) begin
                     pi_count_d = pi_count + CNT_WIDTH'(1);
                  end
               end else begin
                  pi_count_d = '0;
                  rr_last_d  = winner;
               end
            end
         end
         BUSY: begin
            if (mem_ack) begin
               mem_request_d = 1'b0;
               if (!mem_write) rdata_d = mem_rdata;
               ack_d = 3'b001 << grant_id;
            end
         end
         DONE: begin
            grant_id_d = NO_GRANT;
         end
         default: ;
      endcase
   end

   // Output and arbitration registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack         <= 3'b000;
         rdata       <= '0;
         mem_request <= 1'b0;
         mem_write   <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= '0;
         mem_wmask   <= '0;
         grant_id    <= NO_GRANT;
         rr_last     <= 2'd2;
         pi_count    <= '0;
      end else begin
         ack         <= ack_d;
         rdata       <= rdata_d;
         mem_request <= mem_request_d;
         mem_write   <= mem_write_d;
         mem_address <= mem_address_d;
         mem_wdata   <= mem_wdata_d;
         mem_wmask   <= mem_wmask_d;
         grant_id    <= grant_id_d;
         rr_last     <= rr_last_d;
         pi_count    <= pi_count_d;
      end
   end

endmodule
